instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Initiator side of the Instruction_Memory read interface: owns the PC, drives A_IM and
//  registers the decoded fields (OPCODE/FUNCT3/FUNCT7/RA/RB/RW/EU) into a one-entry fetch
//  buffer for the decode stage. Handles start/halt, downstream back-pressure and branch redirect.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset and on START_IF
//  MEM_BYTES  32'd1024       IM size in bytes; fetch at PC >= MEM_BYTES is an error
// PORTS
//  CLK          in   1   clock, all state on posedge
//  RST          in   1   asynchronous, active-high reset
//  START_IF     in   1   pulse: leave IDLE/HALT, PC<=RESET_PC
//  READY_IF     in   1   decode stage accepts the buffered instruction this cycle
//  BR_TAKEN_IF  in   1   redirect request (flush + new PC)
//  BR_TARGET_IF in   32  redirect target byte address
//  A_IM         out  32  address to Instruction_Memory (= PC, combinational from register)
//  OPCODE_IM,FUNCT3_IM,FUNCT7_IM,RA_IM,RB_IM,RW_IM,EU_IM  in  7,3,7,5,5,5,25  fields from IM
//  VALID_IF     out  1   fetch buffer holds an instruction
//  PC_IF        out  32  byte address of buffered instruction
//  OPCODE_IF,FUNCT3_IF,FUNCT7_IF,RA_IF,RB_IF,RW_IF,EU_IF  out  same widths  buffered fields
//  HALT_IF      out  1   unit in HALT
//  ERR_IF       out  1   sticky: misaligned target or out-of-range fetch
// BEHAVIOUR
//  - Reset: state IDLE, PC=RESET_PC, VALID_IF=0, PC_IF=0, all field outs 0, HALT_IF=0, ERR_IF=0.
//  - IM is combinational; fields for PC are sampled at the same edge PC advances (1-cycle latency).
//  - "take" = VALID_IF==0 || READY_IF. Handshake: instruction consumed on edge where VALID&&READY.
//  - IDLE: no fetch. START_IF -> RUN, PC<=RESET_PC, ERR_IF<=0.
//  - RUN, no redirect: if take: buffer<=fields, PC_IF<=PC, VALID<=1, PC<=PC+4 (32-bit wrap).
//    If !take: -> HOLD, buffer and PC frozen.
//  - HOLD: outputs stable; READY_IF -> load as in RUN same edge, -> RUN.
//  - Redirect (BR_TAKEN_IF in RUN/HOLD): highest priority; VALID<=0, PC<=BR_TARGET_IF, -> RUN.
//    Branch and stall same cycle: redirect wins. Branch while IDLE/HALT: ignored.
//  - BR_TARGET_IF[1:0]!=0: -> HALT, ERR_IF<=1, VALID<=0, PC unchanged.
//  - Fetch when PC >= MEM_BYTES: no load, -> HALT, ERR_IF<=1; buffered instr kept until consumed.
//  - Loaded OPCODE==7'b1110011 (SYSTEM/ECALL): loaded normally, then -> HALT (no further fetch);
//    VALID_IF held until consumed. ERR_IF stays 0.
//  - HALT: HALT_IF=1, A_IM holds last PC; START_IF -> RUN at RESET_PC, ERR_IF cleared.
//  - START_IF while RUN/HOLD: restart: VALID<=0, PC<=RESET_PC. START and BR_TAKEN same cycle: START wins.
//  - RST asserted mid-operation: immediate return to reset values, no edge required.
// STRUCTURE
//  - Shared pkg/defines: state encoding (IDLE=2'd0,RUN=2'd1,HOLD=2'd2,HALT=2'd3),
//    OPC_SYSTEM=7'b1110011, field widths.
//  - One sub-module: fetch_buffer (one-entry register of PC + 7 fields with load/clear).
//  - FSM + PC register in top; A_IM = PC.
// TESTING (bench instantiates Instruction_Memory + this unit)
//  - RST then START_IF, READY_IF=1: A_IM 0,4,8,...; VALID_IF from 2nd cycle, PC_IF lags A_IM by 4.
//  - READY_IF=0 3 cycles at PC_IF=8: HOLD, outputs stable; READY_IF=1 -> next PC_IF=12, no skip/dup.
//  - BR_TAKEN_IF=1, target 0x40, READY_IF=0 same cycle: VALID_IF=0 next; next PC_IF=0x40.
//  - Target 0x42: HALT_IF=1, ERR_IF=1, VALID_IF=0; START_IF -> A_IM=RESET_PC, ERR_IF=0.
//  - Run to PC=MEM_BYTES: last PC_IF=MEM_BYTES-4 delivered, then HALT_IF=1, ERR_IF=1.
//  - RST pulsed mid-HOLD between edges: all outputs 0 immediately, IDLE until START_IF.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared encodings, field widths and fetch payload layout for the instruction fetch unit.
package instruction_fetch_unit_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned FUNCT3_W = 3;
  localparam int unsigned FUNCT7_W = 7;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned EU_W     = 25;

  localparam logic [OPCODE_W-1:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [FUNCT3_W-1:0] funct3;
    logic [FUNCT7_W-1:0] funct7;
    logic [REG_W-1:0]    ra;
    logic [REG_W-1:0]    rb;
    logic [REG_W-1:0]    rw;
    logic [EU_W-1:0]     eu;
  } fetch_fields_t;

  localparam int unsigned FIELDS_W = $bits(fetch_fields_t);

endpackage

// File: rtl/instruction_fetch_unit_fetch_buffer.sv
// One-entry fetch buffer: holds PC and decoded fields of one instruction for the decode stage.
module instruction_fetch_unit_fetch_buffer
  import instruction_fetch_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                clr,
  input  logic [XLEN-1:0]     pc_in,
  input  logic [FIELDS_W-1:0] fields_in,
  output logic                valid,
  output logic [XLEN-1:0]     pc,
  output logic [FIELDS_W-1:0] fields
);

  logic                valid_q, valid_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [FIELDS_W-1:0] fields_q, fields_d;

  // Load has priority over clear so a consume-and-refill edge keeps the entry valid.
  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    fields_d = fields_q;
    if (load) begin
      valid_d  = 1'b1;
      pc_d     = pc_in;
      fields_d = fields_in;
    end else if (clr) begin
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      fields_q <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      fields_q <= fields_d;
    end
  end

  assign valid  = valid_q;
  assign pc     = pc_q;
  assign fields = fields_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the instruction memory address and
// fills a one-entry buffer for decode, with start/halt, back-pressure and branch redirect.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] MEM_BYTES = 32'd1024
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START_IF,
  input  logic                READY_IF,
  input  logic                BR_TAKEN_IF,
  input  logic [XLEN-1:0]     BR_TARGET_IF,
  output logic [XLEN-1:0]     A_IM,
  input  logic [OPCODE_W-1:0] OPCODE_IM,
  input  logic [FUNCT3_W-1:0] FUNCT3_IM,
  input  logic [FUNCT7_W-1:0] FUNCT7_IM,
  input  logic [REG_W-1:0]    RA_IM,
  input  logic [REG_W-1:0]    RB_IM,
  input  logic [REG_W-1:0]    RW_IM,
  input  logic [EU_W-1:0]     EU_IM,
  output logic                VALID_IF,
  output logic [XLEN-1:0]     PC_IF,
  output logic [OPCODE_W-1:0] OPCODE_IF,
  output logic [FUNCT3_W-1:0] FUNCT3_IF,
  output logic [FUNCT7_W-1:0] FUNCT7_IF,
  output logic [REG_W-1:0]    RA_IF,
  output logic [REG_W-1:0]    RB_IF,
  output logic [REG_W-1:0]    RW_IF,
  output logic [EU_W-1:0]     EU_IF,
  output logic                HALT_IF,
  output logic                ERR_IF
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            err_q, err_d;
  logic            halt_q, halt_d;
  logic            buf_load, buf_clr, take;
  fetch_fields_t   im_fields, buf_fields;

  assign im_fields = '{opcode: OPCODE_IM, funct3: FUNCT3_IM, funct7: FUNCT7_IM,
                       ra: RA_IM, rb: RB_IM, rw: RW_IM, eu: EU_IM};

  // Priority in RUN/HOLD: restart, then redirect, then stall, then fetch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    err_d    = err_q;
    buf_load = 1'b0;
    buf_clr  = 1'b0;
    take     = ~VALID_IF | READY_IF;
    case (state_q)
      S_IDLE: begin
        if (START_IF) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
          err_d   = 1'b0;
          buf_clr = 1'b1;
        end
      end
      S_RUN, S_HOLD: begin
        if (START_IF) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
          buf_clr = 1'b1;
        end else if (BR_TAKEN_IF) begin
          buf_clr = 1'b1;
          if (BR_TARGET_IF[1:0] != 2'b00) begin
            state_d = S_HALT;
            err_d   = 1'b1;
          end else begin
            state_d = S_RUN;
            pc_d    = BR_TARGET_IF;
          end
        end else if (!take) begin
          state_d = S_HOLD;
        end else if (pc_q >= MEM_BYTES) begin
          // Any buffered entry is consumed on this edge since take implies ready.
          state_d = S_HALT;
          err_d   = 1'b1;
          buf_clr = 1'b1;
        end else begin
          buf_load = 1'b1;
          pc_d     = pc_q + 32'd4;
          state_d  = (OPCODE_IM == OPC_SYSTEM) ? S_HALT : S_RUN;
        end
      end
      S_HALT: begin
        if (START_IF) begin
          state_d = S_RUN;
          pc_d    = RESET_PC;
          err_d   = 1'b0;
          buf_clr = 1'b1;
        end else if (VALID_IF && READY_IF) begin
          buf_clr = 1'b1;
        end
      end
    endcase
    halt_d = (state_d == S_HALT);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      err_q   <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      halt_q  <= halt_d;
    end
  end

  instruction_fetch_unit_fetch_buffer u_fetch_buffer (
    .clk       (CLK),
    .rst       (RST),
    .load      (buf_load),
    .clr       (buf_clr),
    .pc_in     (pc_q),
    .fields_in (im_fields),
    .valid     (VALID_IF),
    .pc        (PC_IF),
    .fields    (buf_fields)
  );

  assign A_IM      = pc_q;
  assign HALT_IF   = halt_q;
  assign ERR_IF    = err_q;
  assign OPCODE_IF = buf_fields.opcode;
  assign FUNCT3_IF = buf_fields.funct3;
  assign FUNCT7_IF = buf_fields.funct7;
  assign RA_IF     = buf_fields.ra;
  assign RB_IF     = buf_fields.rb;
  assign RW_IF     = buf_fields.rw;
  assign EU_IF     = buf_fields.eu;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: combinational instruction memory model, directed
// stimulus, and a scoreboard that checks every instruction accepted by decode.
module tb_instruction_fetch_unit;

  logic        CLK;
  logic        RST;
  logic        START_IF, READY_IF, BR_TAKEN_IF;
  logic [31:0] BR_TARGET_IF;
  logic [31:0] A_IM;
  logic [6:0]  OPCODE_IM, FUNCT7_IM, OPCODE_IF, FUNCT7_IF;
  logic [2:0]  FUNCT3_IM, FUNCT3_IF;
  logic [4:0]  RA_IM, RB_IM, RW_IM, RA_IF, RB_IF, RW_IF;
  logic [24:0] EU_IM, EU_IF;
  logic        VALID_IF, HALT_IF, ERR_IF;
  logic [31:0] PC_IF;

  logic [31:0] sys_addr;
  int          n_chk;
  int          n_fail;

  typedef struct packed {
    logic [31:0] pc;
    logic [56:0] f;
  } exp_t;
  exp_t exp_q[$];

  instruction_fetch_unit dut (
    .CLK(CLK), .RST(RST), .START_IF(START_IF), .READY_IF(READY_IF),
    .BR_TAKEN_IF(BR_TAKEN_IF), .BR_TARGET_IF(BR_TARGET_IF), .A_IM(A_IM),
    .OPCODE_IM(OPCODE_IM), .FUNCT3_IM(FUNCT3_IM), .FUNCT7_IM(FUNCT7_IM),
    .RA_IM(RA_IM), .RB_IM(RB_IM), .RW_IM(RW_IM), .EU_IM(EU_IM),
    .VALID_IF(VALID_IF), .PC_IF(PC_IF), .OPCODE_IF(OPCODE_IF), .FUNCT3_IF(FUNCT3_IF),
    .FUNCT7_IF(FUNCT7_IF), .RA_IF(RA_IF), .RB_IF(RB_IF), .RW_IF(RW_IF), .EU_IF(EU_IF),
    .HALT_IF(HALT_IF), .ERR_IF(ERR_IF)
  );

  // Memory contents are a fixed function of the address; one address may hold SYSTEM.
  function automatic logic [56:0] im_word(input logic [31:0] a);
    logic [6:0]  opc;
    logic [24:0] eu;
    opc = (a == sys_addr) ? 7'b1110011 : 7'b0110011;
    eu  = a[26:2] ^ 25'(a[31:27]) ^ 25'(a[1:0]);
    return {opc, a[4:2], a[8:2], a[6:2], a[11:7], a[6:2] ^ 5'h1f, eu};
  endfunction

  assign {OPCODE_IM, FUNCT3_IM, FUNCT7_IM, RA_IM, RB_IM, RW_IM, EU_IM} = im_word(A_IM);

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc = pc;
    e.f  = im_word(pc);
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every handshake must match the next expected instruction.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST && VALID_IF && READY_IF) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got pc %h expected no delivery", PC_IF);
        end else begin
          e = exp_q.pop_front();
          if (PC_IF !== e.pc ||
              {OPCODE_IF, FUNCT3_IF, FUNCT7_IF, RA_IF, RB_IF, RW_IF, EU_IF} !== e.f) begin
            n_fail++;
            $display("FAIL sb_delivery: got pc %h fields %h expected pc %h fields %h",
                     PC_IF, {OPCODE_IF, FUNCT3_IF, FUNCT7_IF, RA_IF, RB_IF, RW_IF, EU_IF},
                     e.pc, e.f);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_fail = 0;
    sys_addr = 32'hFFFF_FFFF;
    RST = 1'b1; START_IF = 1'b0; READY_IF = 1'b0; BR_TAKEN_IF = 1'b0; BR_TARGET_IF = '0;
    tick(); tick();
    RST = 1'b0;
    chk("rst_a_im", A_IM, 32'h0);
    chk("rst_valid", 32'(VALID_IF), 32'h0);
    chk("rst_pc_if", PC_IF, 32'h0);
    chk("rst_halt", 32'(HALT_IF), 32'h0);
    chk("rst_err", 32'(ERR_IF), 32'h0);
    chk("rst_opcode", 32'(OPCODE_IF), 32'h0);
    tick(); tick();
    chk("idle_a_im", A_IM, 32'h0);
    chk("idle_valid", 32'(VALID_IF), 32'h0);

    // Start and stream with decode always ready
    START_IF = 1'b1; READY_IF = 1'b1;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    tick(); START_IF = 1'b0;
    chk("start_a_im", A_IM, 32'h0);
    chk("start_valid", 32'(VALID_IF), 32'h0);
    tick();
    chk("run0_a_im", A_IM, 32'h4);
    chk("run0_valid", 32'(VALID_IF), 32'h1);
    chk("run0_pc_if", PC_IF, 32'h0);
    tick();
    chk("run1_pc_if", PC_IF, 32'h4);
    chk("run1_a_im", A_IM, 32'h8);
    tick();
    READY_IF = 1'b0;
    chk("run2_pc_if", PC_IF, 32'h8);

    // Back-pressure for three edges
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_pc_if", PC_IF, 32'h8);
      chk("hold_a_im", A_IM, 32'hC);
      chk("hold_valid", 32'(VALID_IF), 32'h1);
    end
    READY_IF = 1'b1;
    tick();
    chk("release_pc_if", PC_IF, 32'hC);
    chk("release_a_im", A_IM, 32'h10);

    // Redirect together with a stall
    READY_IF = 1'b0; BR_TAKEN_IF = 1'b1; BR_TARGET_IF = 32'h40;
    tick();
    BR_TAKEN_IF = 1'b0; READY_IF = 1'b1;
    chk("br_valid", 32'(VALID_IF), 32'h0);
    chk("br_a_im", A_IM, 32'h40);
    push_exp(32'h40);
    tick();
    chk("br_pc_if", PC_IF, 32'h40);
    tick();
    READY_IF = 1'b0;
    chk("br_next_pc_if", PC_IF, 32'h44);

    // Misaligned redirect target
    BR_TAKEN_IF = 1'b1; BR_TARGET_IF = 32'h42;
    tick();
    BR_TAKEN_IF = 1'b0;
    chk("mis_halt", 32'(HALT_IF), 32'h1);
    chk("mis_err", 32'(ERR_IF), 32'h1);
    chk("mis_valid", 32'(VALID_IF), 32'h0);
    chk("mis_a_im", A_IM, 32'h48);
    BR_TAKEN_IF = 1'b1; BR_TARGET_IF = 32'h80;
    tick();
    BR_TAKEN_IF = 1'b0;
    chk("halt_br_ignored_a_im", A_IM, 32'h48);
    chk("halt_br_ignored_halt", 32'(HALT_IF), 32'h1);
    START_IF = 1'b1;
    tick();
    START_IF = 1'b0;
    chk("restart_a_im", A_IM, 32'h0);
    chk("restart_err", 32'(ERR_IF), 32'h0);
    chk("restart_halt", 32'(HALT_IF), 32'h0);

    // START and BR_TAKEN in the same cycle
    READY_IF = 1'b1;
    push_exp(32'h0);
    tick();
    tick();
    chk("sb_pre_pc_if", PC_IF, 32'h4);
    READY_IF = 1'b0; START_IF = 1'b1; BR_TAKEN_IF = 1'b1; BR_TARGET_IF = 32'h80;
    tick();
    START_IF = 1'b0; BR_TAKEN_IF = 1'b0;
    chk("start_wins_a_im", A_IM, 32'h0);
    chk("start_wins_valid", 32'(VALID_IF), 32'h0);

    // SYSTEM opcode halts after being buffered
    sys_addr = 32'h10; READY_IF = 1'b1;
    for (int i = 0; i < 5; i++) push_exp(32'(i * 4));
    for (int i = 0; i < 5; i++) tick();
    READY_IF = 1'b0;
    chk("sys_pc_if", PC_IF, 32'h10);
    chk("sys_opcode", 32'(OPCODE_IF), 32'h73);
    chk("sys_halt", 32'(HALT_IF), 32'h1);
    chk("sys_err", 32'(ERR_IF), 32'h0);
    chk("sys_a_im", A_IM, 32'h14);
    tick(); tick();
    chk("sys_hold_valid", 32'(VALID_IF), 32'h1);
    chk("sys_hold_a_im", A_IM, 32'h14);
    READY_IF = 1'b1;
    tick();
    chk("sys_consumed_valid", 32'(VALID_IF), 32'h0);
    sys_addr = 32'hFFFF_FFFF;

    // Run off the end of memory
    START_IF = 1'b1;
    tick();
    START_IF = 1'b0;
    for (int i = 0; i < 256; i++) push_exp(32'(i * 4));
    for (int i = 0; i < 256; i++) tick();
    chk("end_pc_if", PC_IF, 32'd1020);
    chk("end_valid", 32'(VALID_IF), 32'h1);
    chk("end_halt_pre", 32'(HALT_IF), 32'h0);
    chk("end_a_im", A_IM, 32'd1024);
    tick();
    chk("oor_halt", 32'(HALT_IF), 32'h1);
    chk("oor_err", 32'(ERR_IF), 32'h1);
    chk("oor_valid", 32'(VALID_IF), 32'h0);

    // Asynchronous reset in the middle of a HOLD
    START_IF = 1'b1;
    tick();
    START_IF = 1'b0;
    push_exp(32'h0);
    tick(); tick();
    READY_IF = 1'b0;
    tick();
    chk("pre_rst_pc_if", PC_IF, 32'h4);
    #2;
    RST = 1'b1;
    #1;
    chk("async_rst_valid", 32'(VALID_IF), 32'h0);
    chk("async_rst_pc_if", PC_IF, 32'h0);
    chk("async_rst_a_im", A_IM, 32'h0);
    chk("async_rst_rw", 32'(RW_IF), 32'h0);
    chk("async_rst_eu", 32'(EU_IF), 32'h0);
    chk("async_rst_err", 32'(ERR_IF), 32'h0);
    tick();
    RST = 1'b0; READY_IF = 1'b1;
    tick(); tick();
    chk("post_rst_idle_a_im", A_IM, 32'h0);
    chk("post_rst_idle_valid", 32'(VALID_IF), 32'h0);
    START_IF = 1'b1;
    push_exp(32'h0);
    tick();
    START_IF = 1'b0;
    tick();
    chk("post_rst_pc_if", PC_IF, 32'h0);
    chk("post_rst_valid", 32'(VALID_IF), 32'h1);
    tick();
    READY_IF = 1'b0;
    tick(); tick();
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
